// File: rtl/timer.sv
// Memory-mapped down-counting timer: 16-bit prescaler, reloadable counter,
// one-shot / auto-reload modes, sticky expiry flag and level interrupt.
module timer #(
  parameter int BITS     = 16,
  parameter int CLK_FREQ = 10000000
) (
  input  logic            CLK,
  input  logic            RSTb,
  input  logic [3:0]      ADDRESS,
  input  logic [BITS-1:0] DATA_IN,
  output logic [BITS-1:0] DATA_OUT,
  input  logic            WR,
  output logic            irq
);

  localparam logic [3:0] A_CTRL     = 4'h0;
  localparam logic [3:0] A_PRESCALE = 4'h1;
  localparam logic [3:0] A_RELOAD   = 4'h2;
  localparam logic [3:0] A_COUNT    = 4'h3;
  localparam logic [3:0] A_STATUS   = 4'h4;
  localparam logic [BITS-1:0] ONE   = {{(BITS-1){1'b0}}, 1'b1};

  // CLK_FREQ documents the intended clock only; nothing is derived from it.
  if (CLK_FREQ > 0) begin : g_clk_freq_doc
  end

  logic            en, auto_rl, ie, exp_flag;
  logic [BITS-1:0] prescale, reload, count, pcnt;

  logic            en_n, auto_n, ie_n, exp_n, irq_n;
  logic [BITS-1:0] prescale_n, reload_n, count_n, pcnt_n;

  logic wr_ctrl, wr_pre, wr_rel, wr_cnt, wr_stat;
  logic tick, stop, tick_eff, expire;

  always_comb begin
    wr_ctrl  = WR && (ADDRESS == A_CTRL);
    wr_pre   = WR && (ADDRESS == A_PRESCALE);
    wr_rel   = WR && (ADDRESS == A_RELOAD);
    wr_cnt   = WR && (ADDRESS == A_COUNT);
    wr_stat  = WR && (ADDRESS == A_STATUS);

    tick     = en && (pcnt == prescale);
    // A CTRL write clearing EN suppresses the tick on that same edge.
    stop     = wr_ctrl && !DATA_IN[0];
    tick_eff = tick && !stop;
    expire   = tick_eff && (count == '0);

    en_n       = en;
    auto_n     = auto_rl;
    ie_n       = ie;
    prescale_n = wr_pre ? DATA_IN : prescale;
    reload_n   = wr_rel ? DATA_IN : reload;

    if (wr_ctrl) begin
      en_n   = DATA_IN[0];
      auto_n = DATA_IN[1];
      ie_n   = DATA_IN[2];
    end else if (expire && !auto_rl) begin
      en_n = 1'b0;
    end

    // A direct COUNT write overrides whatever the tick would have done.
    count_n = count;
    if (wr_cnt) begin
      count_n = DATA_IN;
    end else if (tick_eff) begin
      if (count != '0)  count_n = count - ONE;
      else if (auto_rl) count_n = reload;
    end

    // Setting beats clearing when both land on the same edge.
    exp_n = exp_flag;
    if (expire)                     exp_n = 1'b1;
    else if (wr_stat && DATA_IN[0]) exp_n = 1'b0;

    if (!en || stop || wr_pre || tick) pcnt_n = '0;
    else                               pcnt_n = pcnt + ONE;

    irq_n = exp_n && ie_n;
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      prescale <= '0;
      reload   <= '0;
      count    <= '0;
      pcnt     <= '0;
      exp_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      en       <= en_n;
      auto_rl  <= auto_n;
      ie       <= ie_n;
      prescale <= prescale_n;
      reload   <= reload_n;
      count    <= count_n;
      pcnt     <= pcnt_n;
      exp_flag <= exp_n;
      irq      <= irq_n;
    end
  end

  always_comb begin
    DATA_OUT = '0;
    case (ADDRESS)
      A_CTRL:     DATA_OUT[2:0] = {ie, auto_rl, en};
      A_PRESCALE: DATA_OUT = prescale;
      A_RELOAD:   DATA_OUT = reload;
      A_COUNT:    DATA_OUT = count;
      A_STATUS:   DATA_OUT[0] = exp_flag;
      default:    DATA_OUT = '0;
    endcase
  end

endmodule

// File: tb/tb_timer.sv
// Directed scoreboard bench for the timer: stimulus pushes expected reads,
// a negedge monitor pops and compares DATA_OUT/irq on every read cycle.
module tb_timer;

  localparam logic [3:0] A_CTRL = 4'h0, A_PRE = 4'h1, A_REL = 4'h2,
                         A_CNT  = 4'h3, A_STAT = 4'h4;

  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic [3:0]  ADDRESS = 4'h0;
  logic [15:0] DATA_IN = 16'h0;
  logic [15:0] DATA_OUT;
  logic        WR = 1'b0;
  logic        irq;

  timer #(.BITS(16), .CLK_FREQ(10000000)) dut (
    .CLK(CLK), .RSTb(RSTb), .ADDRESS(ADDRESS), .DATA_IN(DATA_IN),
    .DATA_OUT(DATA_OUT), .WR(WR), .irq(irq)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [15:0] data;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  logic chk = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Monitor: whenever a read cycle is presented, pop and compare.
  always @(negedge CLK) begin
    if (chk) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: read presented with no expected entry (DATA_OUT=%h)", DATA_OUT);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (DATA_OUT !== e.data || irq !== e.irq) begin
          n_fail++;
          $display("FAIL %s: got DATA_OUT=%h irq=%b, required DATA_OUT=%h irq=%b",
                   e.name, DATA_OUT, irq, e.data, e.irq);
        end
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    ADDRESS = a; DATA_IN = d; WR = 1'b1;
    @(posedge CLK); #1;
    WR = 1'b0; DATA_IN = 16'h0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] d, input logic i, input string n);
    exp_t e;
    e.name = n; e.data = d; e.irq = i;
    sb.push_back(e);
    ADDRESS = a; chk = 1'b1;
    @(posedge CLK); #1;
    chk = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  initial begin
    RSTb = 1'b0;
    idle(3);
    rd(A_CTRL, 16'h0, 1'b0, "reset_ctrl");
    rd(A_CNT,  16'h0, 1'b0, "reset_count");
    RSTb = 1'b1;
    idle(1);

    // Auto-reload: PRESCALE=0, RELOAD=3, COUNT=3, CTRL=7
    wr(A_PRE, 16'd0);
    wr(A_REL, 16'd3);
    wr(A_CNT, 16'd3);
    wr(A_CTRL, 16'h0007);
    rd(A_CNT, 16'd3, 1'b0, "auto_cnt3");
    rd(A_CNT, 16'd2, 1'b0, "auto_cnt2");
    rd(A_CNT, 16'd1, 1'b0, "auto_cnt1");
    rd(A_CNT, 16'd0, 1'b0, "auto_cnt0");
    rd(A_CNT, 16'd3, 1'b1, "auto_reload");
    rd(A_STAT, 16'd1, 1'b1, "auto_exp");
    wr(A_STAT, 16'd1);
    rd(A_CNT, 16'd0, 1'b0, "auto_cleared");
    rd(A_CNT, 16'd3, 1'b1, "auto_second_expiry");

    // Asynchronous reset while running with irq high
    RSTb = 1'b0;
    rd(A_CNT,  16'h0, 1'b0, "async_reset_count");
    rd(A_CTRL, 16'h0, 1'b0, "async_reset_ctrl");
    rd(A_PRE,  16'h0, 1'b0, "async_reset_prescale");
    rd(A_REL,  16'h0, 1'b0, "async_reset_reload");
    rd(A_STAT, 16'h0, 1'b0, "async_reset_status");
    RSTb = 1'b1;
    idle(1);

    // Unmapped writes and CTRL masking
    wr(4'h5, 16'hffff);
    wr(4'hf, 16'hffff);
    rd(4'h5,   16'h0, 1'b0, "unmapped_5");
    rd(4'hf,   16'h0, 1'b0, "unmapped_f");
    rd(A_CTRL, 16'h0, 1'b0, "unmapped_ctrl");
    rd(A_PRE,  16'h0, 1'b0, "unmapped_prescale");
    rd(A_REL,  16'h0, 1'b0, "unmapped_reload");
    rd(A_CNT,  16'h0, 1'b0, "unmapped_count");
    wr(A_CTRL, 16'hffff);
    rd(A_CTRL, 16'h0007, 1'b0, "ctrl_mask");
    rd(A_STAT, 16'd1, 1'b1, "ctrl_all_expiry");
    wr(A_CTRL, 16'h0000);
    wr(A_STAT, 16'd1);

    // Prescaled one-shot: PRESCALE=9, COUNT=2, CTRL=5
    wr(A_PRE, 16'd9);
    wr(A_CNT, 16'd2);
    wr(A_CTRL, 16'h0005);
    idle(9);
    rd(A_CNT, 16'd2, 1'b0, "oneshot_pre_tick1");
    rd(A_CNT, 16'd1, 1'b0, "oneshot_tick1");
    idle(8);
    rd(A_CNT, 16'd1, 1'b0, "oneshot_pre_tick2");
    rd(A_CNT, 16'd0, 1'b0, "oneshot_tick2");
    idle(8);
    rd(A_STAT, 16'd0, 1'b0, "oneshot_pre_expiry");
    rd(A_STAT, 16'd1, 1'b1, "oneshot_expiry_30");
    rd(A_CTRL, 16'h0004, 1'b1, "oneshot_ctrl");
    idle(20);
    rd(A_CNT, 16'd0, 1'b1, "oneshot_count_held");
    wr(A_STAT, 16'd0);
    rd(A_STAT, 16'd1, 1'b1, "status_write0_noop");
    wr(A_STAT, 16'd1);
    rd(A_STAT, 16'd0, 1'b0, "status_clear");

    // IE masking
    wr(A_PRE, 16'd0);
    wr(A_CNT, 16'd1);
    wr(A_CTRL, 16'h0001);
    idle(2);
    rd(A_STAT, 16'd1, 1'b0, "ie_masked");
    rd(A_CNT,  16'd0, 1'b0, "ie_count0");
    wr(A_CTRL, 16'h0004);
    rd(A_STAT, 16'd1, 1'b1, "ie_unmasked");
    rd(A_CTRL, 16'h0004, 1'b1, "ie_ctrl");

    // COUNT write on a tick cycle, then stop
    wr(A_CNT, 16'h0050);
    wr(A_STAT, 16'd1);
    wr(A_CTRL, 16'h0001);
    wr(A_CNT, 16'h0100);
    rd(A_CNT, 16'h0100, 1'b0, "count_write_wins");
    rd(A_CNT, 16'h00ff, 1'b0, "count_after_write");
    wr(A_CTRL, 16'h0000);
    rd(A_CNT, 16'h00fe, 1'b0, "stop_hold");
    idle(3);
    rd(A_CNT, 16'h00fe, 1'b0, "stop_hold_later");

    // STATUS clear on the expiry edge
    wr(A_REL, 16'd5);
    wr(A_CNT, 16'd1);
    wr(A_CTRL, 16'h0003);
    rd(A_CNT, 16'd1, 1'b0, "col_pre");
    wr(A_STAT, 16'd1);
    rd(A_STAT, 16'd1, 1'b0, "status_set_wins");
    rd(A_CNT, 16'd4, 1'b0, "col_reloaded");
    rd(A_CNT, 16'd3, 1'b0, "col_running");
    wr(A_CTRL, 16'h0000);

    idle(2);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
